link_upstream_sender: RTL and testbench

LINK_UPSTREAM_SENDER -- requirements
Module: link_upstream_sender

---
 rtl/link_upstream_sender.sv | 60 ++++++
 tb/tb_link_upstream_sender.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/link_upstream_sender.sv
// link_upstream_sender: credit-flow-controlled 16-bit to 8-bit serializer for an upstream link.
module link_upstream_sender #(
  parameter int CREDITS     = 16,
  parameter int TOKEN_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [15:0]                      core_data_i,
  input  logic                             core_valid_i,
  output logic                             core_ready_o,
  output logic [7:0]                       io_data_o,
  output logic                             io_valid_o,
  input  logic                             token_i,
  output logic [$clog2(CREDITS+1)-1:0]     credit_o,
  output logic                             overflow_o
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW:0] RATIO = (CW+1)'(TOKEN_RATIO);
  localparam logic [CW:0] CMAX  = (CW+1)'(CREDITS);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t        state_q, state_d;
  logic [15:0]   hold_q;
  logic          token_q;
  logic [CW-1:0] credit_q;
  logic          overflow_q;
  logic [CW:0]   credit_d;
  logic          accept, token_edge;

  assign core_ready_o = (credit_q != '0) && (state_q == IDLE || state_q == SEND_HI);
  assign accept       = core_valid_i && core_ready_o;
  assign token_edge   = token_i ^ token_q;
  assign io_valid_o   = state_q != IDLE;
  assign io_data_o    = state_q == SEND_LO ? hold_q[7:0] : state_q == SEND_HI ? hold_q[15:8] : 8'h00;
  assign credit_o     = credit_q;
  assign overflow_o   = overflow_q;

  always_comb begin
    state_d  = state_q == SEND_LO ? SEND_HI : accept ? SEND_LO : IDLE;
    credit_d = {1'b0, credit_q} + (token_edge ? RATIO : '0) - {{CW{1'b0}}, accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      token_q    <= 1'b0;
      credit_q   <= CMAX[CW-1:0];
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      token_q  <= token_i;
      if (accept) hold_q <= core_data_i;
      // excess returned credits are clamped and remembered as a sticky error
      credit_q <= credit_d > CMAX ? CMAX[CW-1:0] : credit_d[CW-1:0];
      if (credit_d > CMAX) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_link_upstream_sender.sv
// tb_link_upstream_sender: directed stimulus with a byte scoreboard checked by an independent monitor.
module tb_link_upstream_sender;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] core_data_i = '0;
  logic        core_valid_i = 1'b0;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic        token_i = 1'b0;
  logic [4:0]  credit_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int run = 0;
  int last_run = 0;

  link_upstream_sender #(.CREDITS(16), .TOKEN_RATIO(4)) dut (
    .clk(clk), .rst(rst), .core_data_i(core_data_i), .core_valid_i(core_valid_i),
    .core_ready_o(core_ready_o), .io_data_o(io_data_o), .io_valid_o(io_valid_o),
    .token_i(token_i), .credit_o(credit_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every valid byte must match the oldest expected byte
  always @(negedge clk) begin
    if (io_valid_o) begin
      run++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL io_byte: got unexpected 0x%02h expected no byte", io_data_o);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (io_data_o !== e) begin
          errors++;
          $display("FAIL io_byte: got 0x%02h expected 0x%02h", io_data_o, e);
        end
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_valid_i = 1'b0;
    token_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // holds valid across the SEND_LO edge; returns one step into SEND_HI
  task automatic send(input logic [15:0] w);
    core_valid_i = 1'b1;
    core_data_i = w;
    @(posedge clk);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    #1;
    chk("ready_in_send_lo", int'(core_ready_o), 0);
    step();
  endtask

  task automatic sample(input string name, input int c, input int rdy, input int v, input int ov);
    @(negedge clk);
    chk({name, "_credit"}, int'(credit_o), c);
    chk({name, "_ready"}, int'(core_ready_o), rdy);
    chk({name, "_io_valid"}, int'(io_valid_o), v);
    chk({name, "_overflow"}, int'(overflow_o), ov);
  endtask

  initial begin
    do_reset();
    sample("reset", 16, 1, 0, 0);
    chk("reset_io_data", int'(io_data_o), 0);

    step();
    send(16'hA55A);
    core_valid_i = 1'b0;
    step();
    sample("single", 15, 1, 0, 0);

    do_reset();
    for (int i = 0; i < 16; i++) send({8'(8'h80 + i), 8'(i)});
    sample("exhaust", 0, 0, 1, 0);
    step();
    step();
    step();
    sample("exhaust_idle", 0, 0, 0, 0);
    chk("contiguous_bytes", last_run, 32);

    core_valid_i = 1'b0;
    token_i = 1'b1;
    step();
    sample("token_return", 4, 1, 0, 0);
    token_i = 1'b0;
    step();
    sample("token_second", 8, 1, 0, 0);
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    chk("before_simul_credit", int'(credit_o), 5);
    token_i = 1'b1;
    send(16'h0F0F);
    core_valid_i = 1'b0;
    sample("simultaneous", 8, 1, 1, 0);
    step();

    token_i = 1'b0;
    step();
    token_i = 1'b1;
    step();
    chk("pre_overflow_full", int'(credit_o), 16);
    send(16'h4444);
    send(16'h5555);
    core_valid_i = 1'b0;
    step();
    chk("pre_overflow_credit", int'(credit_o), 14);
    token_i = 1'b0;
    step();
    sample("overflow", 16, 1, 0, 1);
    send(16'h6666);
    core_valid_i = 1'b0;
    step();
    sample("overflow_sticky", 15, 1, 0, 1);

    core_valid_i = 1'b1;
    core_data_i = 16'h1234;
    @(posedge clk);
    exp_q.push_back(8'h34);
    #1;
    core_valid_i = 1'b0;
    rst = 1'b1;
    token_i = 1'b0;
    step();
    rst = 1'b0;
    sample("reset_mid_word", 16, 1, 0, 0);
    step();
    step();
    sample("after_reset_idle", 16, 1, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
